// File: rtl/bank_mshr_queue.sv
// Per-bank miss-status holding queue: allocates one entry per primary miss, merges
// later stores into pending non-head entries, and presents the oldest entry to the bank.
module bank_mshr_queue #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 20,
   parameter int INDEX_W     = 6,
   parameter int BLOCK_SIZE  = 4,
   parameter int BLOCK_OFF_W = 2,
   parameter int WORD_W      = 32,
   parameter int UUID_W      = 8
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         miss_valid,
   output logic                         miss_ready,
   input  logic [TAG_W-1:0]             miss_tag,
   input  logic [INDEX_W-1:0]           miss_index,
   input  logic [BLOCK_OFF_W-1:0]       miss_block_offset,
   input  logic                         miss_rw,
   input  logic [WORD_W-1:0]            miss_store_value,
   input  logic [UUID_W-1:0]            miss_uuid,
   output logic                         mshr_valid,
   output logic [TAG_W-1:0]             mshr_tag,
   output logic [INDEX_W-1:0]           mshr_index,
   output logic [BLOCK_SIZE-1:0]        mshr_write_status,
   output logic [BLOCK_SIZE*WORD_W-1:0] mshr_write_block,
   output logic [UUID_W-1:0]            mshr_uuid,
   input  logic                         bank_done,
   output logic                         merge_ack,
   output logic [UUID_W-1:0]            merge_ack_uuid,
   output logic [$clog2(NUM_ENTRIES):0] occupancy,
   output logic                         empty
);

   localparam int PTR_W = $clog2(NUM_ENTRIES);
   localparam int CNT_W = PTR_W + 1;
   localparam int BLK_W = BLOCK_SIZE * WORD_W;

   logic                  valid_reg  [NUM_ENTRIES];
   logic [TAG_W-1:0]      tag_reg    [NUM_ENTRIES];
   logic [INDEX_W-1:0]    index_reg  [NUM_ENTRIES];
   logic [UUID_W-1:0]     uuid_reg   [NUM_ENTRIES];
   logic [BLOCK_SIZE-1:0] status_reg [NUM_ENTRIES];
   logic [BLK_W-1:0]      block_reg  [NUM_ENTRIES];

   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              merge_ack_reg;
   logic [UUID_W-1:0] merge_ack_uuid_reg;

   logic [NUM_ENTRIES-1:0] block_match;
   logic [PTR_W-1:0]       probe_slot;
   logic [PTR_W-1:0]       merge_slot;
   logic                   merge_hit;
   logic                   queue_full;
   logic                   head_valid;
   logic                   do_merge;
   logic                   do_alloc;
   logic                   do_pop;
   logic [BLOCK_SIZE-1:0]  alloc_status;
   logic [BLK_W-1:0]       alloc_block;

   generate
      for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : gen_match
         assign block_match[gi] = valid_reg[gi] && (tag_reg[gi] == miss_tag)
                                  && (index_reg[gi] == miss_index);
      end
   endgenerate

   // Walk from just after the head toward the tail so the youngest match wins;
   // the head itself is never probed because the bank may be sampling it.
   always_comb begin
      merge_hit  = 1'b0;
      merge_slot = '0;
      probe_slot = '0;
      for (int k = 1; k < NUM_ENTRIES; k++) begin
         probe_slot = head_reg + PTR_W'(k);
         if ((CNT_W'(k) < count_reg) && block_match[probe_slot] && miss_valid && miss_rw) begin
            merge_hit  = 1'b1;
            merge_slot = probe_slot;
         end
      end
   end

   // A same-cycle pop does not free a slot for the incoming miss.
   assign queue_full = (count_reg == CNT_W'(NUM_ENTRIES));
   assign miss_ready = !queue_full || merge_hit;
   assign do_merge   = miss_valid && miss_ready && merge_hit;
   assign do_alloc   = miss_valid && miss_ready && !merge_hit;
   assign do_pop     = bank_done && (count_reg != '0);

   assign alloc_status = miss_rw ? (BLOCK_SIZE'(1) << miss_block_offset) : '0;
   assign alloc_block  = miss_rw ? (BLK_W'(miss_store_value) << (miss_block_offset * WORD_W)) : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head_reg           <= '0;
         tail_reg           <= '0;
         count_reg          <= '0;
         merge_ack_reg      <= 1'b0;
         merge_ack_uuid_reg <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_reg[i]  <= 1'b0;
            tag_reg[i]    <= '0;
            index_reg[i]  <= '0;
            uuid_reg[i]   <= '0;
            status_reg[i] <= '0;
            block_reg[i]  <= '0;
         end
      end else begin
         if (do_alloc) tail_reg <= tail_reg + PTR_W'(1);
         if (do_pop)   head_reg <= head_reg + PTR_W'(1);
         case ({do_alloc, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         merge_ack_reg      <= do_merge;
         merge_ack_uuid_reg <= do_merge ? miss_uuid : '0;

         // Alloc, merge and pop never target the same slot in one cycle.
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (do_pop && (head_reg == PTR_W'(i))) begin
               valid_reg[i]  <= 1'b0;
               status_reg[i] <= '0;
               block_reg[i]  <= '0;
            end else if (do_alloc && (tail_reg == PTR_W'(i))) begin
               valid_reg[i]  <= 1'b1;
               tag_reg[i]    <= miss_tag;
               index_reg[i]  <= miss_index;
               uuid_reg[i]   <= miss_uuid;
               status_reg[i] <= alloc_status;
               block_reg[i]  <= alloc_block;
            end else if (do_merge && (merge_slot == PTR_W'(i))) begin
               status_reg[i][miss_block_offset] <= 1'b1;
               block_reg[i][miss_block_offset*WORD_W +: WORD_W] <= miss_store_value;
            end
         end
      end
   end

   assign head_valid        = (count_reg != '0);
   assign mshr_valid        = head_valid;
   assign mshr_tag          = head_valid ? tag_reg[head_reg]    : '0;
   assign mshr_index        = head_valid ? index_reg[head_reg]  : '0;
   assign mshr_uuid         = head_valid ? uuid_reg[head_reg]   : '0;
   assign mshr_write_status = head_valid ? status_reg[head_reg] : '0;
   assign mshr_write_block  = head_valid ? block_reg[head_reg]  : '0;
   assign merge_ack         = merge_ack_reg;
   assign merge_ack_uuid    = merge_ack_uuid_reg;
   assign occupancy         = count_reg;
   assign empty             = (count_reg == '0);

endmodule

// File: doc/bank_mshr_queue.md
Name: bank_mshr_queue

Overview:
- Per-bank miss-status holding queue that sits directly upstream of the cache bank.
- Accepts miss requests from the scheduler and allocates one entry per primary miss.
- Merges later write misses into pending non-head entries of the same block.
- Presents the oldest entry to the bank as a single MSHR entry. Dequeues it when the bank signals completion of the fill.

Parameters:
- NUM_ENTRIES, 4, queue depth; must be a power of 2 and at least 2.
- TAG_W, 20, block tag width.
- INDEX_W, 6, set-index field width (full index, before bank select).
- BLOCK_SIZE, 4, words per block.
- BLOCK_OFF_W, 2, log2(BLOCK_SIZE).
- WORD_W, 32, data word width.
- UUID_W, 8, request identifier width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- miss_valid  in  1  scheduler presents a miss.
- miss_ready  out  1  miss accepted this cycle when high together with miss_valid.
- miss_tag  in  TAG_W  block tag.
- miss_index  in  INDEX_W  block index.
- miss_block_offset  in  BLOCK_OFF_W  word within block.
- miss_rw  in  1  1 = store, 0 = load.
- miss_store_value  in  WORD_W  store data.
- miss_uuid  in  UUID_W  request id.
- mshr_valid  out  1  head entry valid.
- mshr_tag  out  TAG_W  head tag.
- mshr_index  out  INDEX_W  head index.
- mshr_write_status  out  BLOCK_SIZE  per-word "store pending" bits of head.
- mshr_write_block  out  BLOCK_SIZE*WORD_W  head store data; word i is at bits [i*WORD_W +: WORD_W].
- mshr_uuid  out  UUID_W  head uuid.
- bank_done  in  1  single-cycle pulse from the bank at fill completion; pops the head.
- merge_ack  out  1  one-cycle pulse when a store was merged.
- merge_ack_uuid  out  UUID_W  uuid of the merged store.
- occupancy  out  log2(NUM_ENTRIES)+1  number of valid entries.
- empty  out  1  occupancy == 0; halt/flush logic waits on this.

Behaviour:
- Reset is asynchronous on nRST low. All entries are invalidated, head and tail pointers go to 0, and the merge_ack register clears. Outputs during and after reset:
  - mshr_* = 0
  - merge_ack = 0, merge_ack_uuid = 0
  - occupancy = 0, empty = 1
  - miss_ready = 1 once nRST is released.
- Storage is a circular buffer with head pointer, tail pointer and count. Pointers wrap modulo NUM_ENTRIES.
- Merge check (combinational): merge_hit is true when all of the following hold:
  - miss_valid && miss_rw;
  - some valid entry other than the head has tag == miss_tag and index == miss_index.
- If several entries match, the youngest matching entry is used.
- miss_ready = (count < NUM_ENTRIES) || merge_hit. A pop in the same cycle is not credited, so a full queue rejects a non-merging miss even while bank_done is high.
- Accepted miss with merge_hit:
  - Set the entry's write_status[offset] and write_block[offset] = store_value.
  - If that word already has a pending store, the newer store overwrites it.
  - No allocation.
  - On the next cycle merge_ack = 1 and merge_ack_uuid = miss_uuid.
- Accepted miss without merge_hit:
  - Allocate at the tail with valid = 1, tag, index and uuid.
  - For a store, write_status has only the bit at offset set and that word of write_block holds the store data.
  - For a load, write_status = 0 and write_block = 0.
  - Tail advances by 1.
- Loads never merge. A load to a block that is already pending allocates its own entry; the bank resolves it as a hit on the already-filled line.
- Stores never merge into the head. The bank may be sampling the head's write_status at any time.
- Outputs are driven combinationally from the head entry. Head output fields are 0 when empty.
- Latency: a miss accepted into an empty queue appears on mshr_valid the following cycle.
- Pop: on bank_done with count > 0, the head entry is invalidated, its write_status and write_block are cleared, and the head advances. bank_done while empty is ignored.
- Allocate and pop in the same cycle: count is unchanged and both pointers move. Merge and pop in the same cycle: the merge target is never the head, so both operations are applied.
- After a pop, the new head holds all stores merged so far. The new head becomes ineligible for merging starting in the same cycle it becomes head.

Test Plan:
- Reset with nRST low mid-traffic at 3 entries → next cycle occupancy = 0, empty = 1, mshr_valid = 0, merge_ack = 0.
- Load miss (tag 0x00AB1, index 5, uuid 7) into empty queue → next cycle mshr_valid = 1, mshr_tag = 0x00AB1, mshr_index = 5, mshr_uuid = 7, write_status = 0000.
- Load A (uuid 1), then load B (tag 0x22, index 3, uuid 2), then store to B offset 2 value 0xDEADBEEF (uuid 3):
  - occupancy stays 2;
  - merge_ack = 1 with uuid 3 one cycle after the store;
  - after bank_done, head = B with write_status = 0100 and word 2 = 0xDEADBEEF.
- Store to the head's block while occupancy = 1 → no merge; a new entry is allocated and occupancy = 2.
- Fill to 4 entries:
  - a non-matching miss sees miss_ready = 0, including in a cycle with bank_done high;
  - a matching store to entry 2 sees miss_ready = 1.
- At occupancy 4, 4 pops interleaved with 4 allocations across wrap-around → uuids emerge in FIFO order, empty = 1 at the end, and bank_done while empty leaves occupancy = 0.
